// File: rtl/axis_tlp_pkg.sv
// Shared types and constants for the two-requester TLP TX arbiter.
package axis_tlp_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_PORTS = 2;
  localparam logic [5:0]  BUF_AV_MIN_DEF = 6'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_GNT0 = 2'd2,
    ST_GNT1 = 2'd3
  } state_e;

endpackage

// File: rtl/axis_tlp_tx_arbiter_if.sv
// AXI4-Stream TLP channel (data, last, valid, ready).
interface axis_tlp_tx_arbiter_if;
  import axis_tlp_pkg::*;

  logic [DATA_W-1:0] TDATA;
  logic              TLAST;
  logic              TVALID;
  logic              TREADY;

  modport master (output TDATA, output TLAST, output TVALID, input TREADY);
  modport slave  (input TDATA, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/axis_tlp_rr_pick.sv
// Two-way round-robin selector: returns the port index to grant.
module axis_tlp_rr_pick
  import axis_tlp_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_served,
  output logic                 pick
);

  // Both requesting: serve the one not served last; otherwise the lone requester.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) begin
      pick = ~last_served;
    end else begin
      pick = req[1];
    end
  end

endmodule

// File: rtl/axis_tlp_tx_arbiter.sv
// Packet-granular arbiter merging two TLP streams (plus config-completion
// slot requests) onto the PCIe core TX stream.
module axis_tlp_tx_arbiter
  import axis_tlp_pkg::*;
#(
  parameter logic [5:0]  BUF_AV_MIN = BUF_AV_MIN_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  axis_tlp_tx_arbiter_if.slave   S0_AXIS,
  axis_tlp_tx_arbiter_if.slave   S1_AXIS,
  axis_tlp_tx_arbiter_if.master  M_AXIS,
  input  logic [5:0]             tx_buf_av,
  input  logic                   tx_cfg_req,
  output logic                   tx_cfg_gnt,
  output logic [CNT_W-1:0]       pkt_cnt0,
  output logic [CNT_W-1:0]       pkt_cnt1
);

  state_e               state_q;
  logic                 cfg_gnt_q;
  logic                 last_served_q;
  logic [CNT_W-1:0]     pkt_cnt0_q;
  logic [CNT_W-1:0]     pkt_cnt1_q;

  logic [NUM_PORTS-1:0] req;
  logic                 pick;
  logic                 gnt0;
  logic                 gnt1;
  logic                 last_beat;

  assign req = {S1_AXIS.TVALID, S0_AXIS.TVALID};

  axis_tlp_rr_pick u_rr_pick (
    .req         (req),
    .last_served (last_served_q),
    .pick        (pick)
  );

  // Reset gates the grant combinationally so an aborted packet stops at once.
  assign gnt0 = ARESETN && (state_q == ST_GNT0);
  assign gnt1 = ARESETN && (state_q == ST_GNT1);

  // Zero-latency pass-through of the granted port; everything quiet otherwise.
  always_comb begin
    M_AXIS.TDATA   = '0;
    M_AXIS.TLAST   = 1'b0;
    M_AXIS.TVALID  = 1'b0;
    S0_AXIS.TREADY = 1'b0;
    S1_AXIS.TREADY = 1'b0;
    if (gnt0) begin
      M_AXIS.TDATA   = S0_AXIS.TDATA;
      M_AXIS.TLAST   = S0_AXIS.TLAST;
      M_AXIS.TVALID  = S0_AXIS.TVALID;
      S0_AXIS.TREADY = M_AXIS.TREADY;
    end else if (gnt1) begin
      M_AXIS.TDATA   = S1_AXIS.TDATA;
      M_AXIS.TLAST   = S1_AXIS.TLAST;
      M_AXIS.TVALID  = S1_AXIS.TVALID;
      S1_AXIS.TREADY = M_AXIS.TREADY;
    end
  end

  assign last_beat = M_AXIS.TVALID & M_AXIS.TREADY & M_AXIS.TLAST;

  // Arbitration FSM, config grant, last-served pointer and packet counters.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q       <= ST_IDLE;
      cfg_gnt_q     <= 1'b0;
      last_served_q <= 1'b1;
      pkt_cnt0_q    <= '0;
      pkt_cnt1_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_cfg_req) begin
            state_q   <= ST_CFG;
            cfg_gnt_q <= 1'b1;
          end else if ((tx_buf_av >= BUF_AV_MIN) && (req != '0)) begin
            state_q <= pick ? ST_GNT1 : ST_GNT0;
          end
        end
        ST_CFG: begin
          if (!tx_cfg_req) begin
            state_q   <= ST_IDLE;
            cfg_gnt_q <= 1'b0;
          end
        end
        ST_GNT0: begin
          if (last_beat) begin
            state_q       <= ST_IDLE;
            last_served_q <= 1'b0;
            pkt_cnt0_q    <= pkt_cnt0_q + CNT_W'(1);
          end
        end
        ST_GNT1: begin
          if (last_beat) begin
            state_q       <= ST_IDLE;
            last_served_q <= 1'b1;
            pkt_cnt1_q    <= pkt_cnt1_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_cfg_gnt = cfg_gnt_q;
  assign pkt_cnt0   = pkt_cnt0_q;
  assign pkt_cnt1   = pkt_cnt1_q;

endmodule

// File: tb/tb_axis_tlp_tx_arbiter.sv
// Directed, table-driven bench for the TLP TX arbiter.
module tb_axis_tlp_tx_arbiter;

  localparam int unsigned CNT_W = 3;

  typedef struct {
    logic        rstn;
    logic        cfg;
    logic [5:0]  bav;
    logic        mr;
    logic        s0v;
    logic [31:0] s0d;
    logic        s0l;
    logic        s1v;
    logic [31:0] s1d;
    logic        s1l;
    logic        mv;
    logic [31:0] md;
    logic        ml;
    logic        r0;
    logic        r1;
    logic        gnt;
    logic [2:0]  c0;
    logic [2:0]  c1;
  } vec_t;

  logic             ACLK;
  logic             ARESETN;
  logic [5:0]       tx_buf_av;
  logic             tx_cfg_req;
  logic             tx_cfg_gnt;
  logic [CNT_W-1:0] pkt_cnt0;
  logic [CNT_W-1:0] pkt_cnt1;

  int passed = 0;
  int total  = 0;
  int vec_id = 0;

  axis_tlp_tx_arbiter_if s0_if ();
  axis_tlp_tx_arbiter_if s1_if ();
  axis_tlp_tx_arbiter_if m_if ();

  axis_tlp_tx_arbiter #(.BUF_AV_MIN(6'd2), .CNT_W(CNT_W)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .S0_AXIS    (s0_if),
    .S1_AXIS    (s1_if),
    .M_AXIS     (m_if),
    .tx_buf_av  (tx_buf_av),
    .tx_cfg_req (tx_cfg_req),
    .tx_cfg_gnt (tx_cfg_gnt),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(
    input logic rstn, input logic cfg, input logic [5:0] bav, input logic mr,
    input logic s0v, input logic [31:0] s0d, input logic s0l,
    input logic s1v, input logic [31:0] s1d, input logic s1l,
    input logic mv, input logic [31:0] md, input logic ml,
    input logic r0, input logic r1, input logic gnt,
    input logic [2:0] c0, input logic [2:0] c1);
    vec_t v;
    v.rstn = rstn; v.cfg = cfg; v.bav = bav; v.mr = mr;
    v.s0v = s0v; v.s0d = s0d; v.s0l = s0l;
    v.s1v = s1v; v.s1d = s1d; v.s1l = s1l;
    v.mv = mv; v.md = md; v.ml = ml;
    v.r0 = r0; v.r1 = r1; v.gnt = gnt; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Drive one cycle of inputs after the falling edge and check the outputs.
  task automatic apply(input string tag, input vec_t v);
    logic [42:0] act;
    logic [42:0] exp;
    @(negedge ACLK);
    ARESETN        = v.rstn;
    tx_cfg_req     = v.cfg;
    tx_buf_av      = v.bav;
    m_if.TREADY    = v.mr;
    s0_if.TVALID   = v.s0v;
    s0_if.TDATA    = v.s0d;
    s0_if.TLAST    = v.s0l;
    s1_if.TVALID   = v.s1v;
    s1_if.TDATA    = v.s1d;
    s1_if.TLAST    = v.s1l;
    #1;
    act = {m_if.TVALID, m_if.TDATA, m_if.TLAST, s0_if.TREADY, s1_if.TREADY,
           tx_cfg_gnt, pkt_cnt0, pkt_cnt1};
    exp = {v.mv, v.md, v.ml, v.r0, v.r1, v.gnt, v.c0, v.c1};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec%0d {mv,md,ml,r0,r1,gnt,c0,c1}: got %h, required %h",
                  tag, vec_id, act, exp);
    vec_id++;
  endtask

  vec_t tbl[$];
  logic [32:0] got[$];
  logic [2:0]  cur;
  bit          done;
  int          idx;
  logic        vpat[16];
  logic        rpat[16];

  initial begin
    ARESETN = 1'b0; tx_cfg_req = 1'b0; tx_buf_av = 6'd2;
    m_if.TREADY = 1'b1;
    s0_if.TVALID = 1'b0; s0_if.TDATA = '0; s0_if.TLAST = 1'b0;
    s1_if.TVALID = 1'b0; s1_if.TDATA = '0; s1_if.TLAST = 1'b0;
    repeat (2) @(posedge ACLK);

    // Reset state, then S0 3-beat packet with S1 idle
    tbl.push_back(mk(0,0,2,1, 0,0,0,       0,0,0,       0,0,0,       0,0,0, 0,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hA0,0,  0,0,0,       0,0,0,       0,0,0, 0,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hA0,0,  0,0,0,       1,32'hA0,0,  1,0,0, 0,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hA1,0,  0,0,0,       1,32'hA1,0,  1,0,0, 0,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hA2,1,  0,0,0,       1,32'hA2,1,  1,0,0, 0,0));
    tbl.push_back(mk(1,0,2,1, 0,0,0,       0,0,0,       0,0,0,       0,0,0, 1,0));
    // Reset, then both requesting 2-beat packets: S0,S1,S0,S1
    tbl.push_back(mk(0,0,2,1, 0,0,0,       0,0,0,       0,0,0,       0,0,0, 1,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hB0,0,  1,32'hC0,0,  0,0,0,       0,0,0, 0,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hB0,0,  1,32'hC0,0,  1,32'hB0,0,  1,0,0, 0,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hB1,1,  1,32'hC0,0,  1,32'hB1,1,  1,0,0, 0,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hB2,0,  1,32'hC0,0,  0,0,0,       0,0,0, 1,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hB2,0,  1,32'hC0,0,  1,32'hC0,0,  0,1,0, 1,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hB2,0,  1,32'hC1,1,  1,32'hC1,1,  0,1,0, 1,0));
    tbl.push_back(mk(1,0,2,1, 1,32'hB2,0,  1,32'hC2,0,  0,0,0,       0,0,0, 1,1));
    tbl.push_back(mk(1,0,2,1, 1,32'hB2,0,  1,32'hC2,0,  1,32'hB2,0,  1,0,0, 1,1));
    tbl.push_back(mk(1,0,2,1, 1,32'hB3,1,  1,32'hC2,0,  1,32'hB3,1,  1,0,0, 1,1));
    tbl.push_back(mk(1,0,2,1, 1,32'hB4,0,  1,32'hC2,0,  0,0,0,       0,0,0, 2,1));
    tbl.push_back(mk(1,0,2,1, 1,32'hB4,0,  1,32'hC2,0,  1,32'hC2,0,  0,1,0, 2,1));
    tbl.push_back(mk(1,0,2,1, 1,32'hB4,0,  1,32'hC3,1,  1,32'hC3,1,  0,1,0, 2,1));
    tbl.push_back(mk(1,0,2,1, 0,0,0,       0,0,0,       0,0,0,       0,0,0, 2,2));
    // Config request beats a simultaneous S1 request
    tbl.push_back(mk(1,1,2,1, 0,0,0,       1,32'hD0,1,  0,0,0,       0,0,0, 2,2));
    tbl.push_back(mk(1,1,2,1, 0,0,0,       1,32'hD0,1,  0,0,0,       0,0,1, 2,2));
    tbl.push_back(mk(1,0,2,1, 0,0,0,       1,32'hD0,1,  0,0,0,       0,0,1, 2,2));
    tbl.push_back(mk(1,0,2,1, 0,0,0,       1,32'hD0,1,  0,0,0,       0,0,0, 2,2));
    tbl.push_back(mk(1,0,2,1, 0,0,0,       1,32'hD0,1,  1,32'hD0,1,  0,1,0, 2,2));
    tbl.push_back(mk(1,0,2,1, 0,0,0,       0,0,0,       0,0,0,       0,0,0, 2,3));
    // Buffer threshold gates new grants but not a packet in flight
    tbl.push_back(mk(1,0,1,1, 1,32'hE0,0,  0,0,0,       0,0,0,       0,0,0, 2,3));
    tbl.push_back(mk(1,0,1,1, 1,32'hE0,0,  0,0,0,       0,0,0,       0,0,0, 2,3));
    tbl.push_back(mk(1,0,2,1, 1,32'hE0,0,  0,0,0,       0,0,0,       0,0,0, 2,3));
    tbl.push_back(mk(1,0,0,1, 1,32'hE0,0,  0,0,0,       1,32'hE0,0,  1,0,0, 2,3));
    tbl.push_back(mk(1,0,0,1, 1,32'hE1,1,  0,0,0,       1,32'hE1,1,  1,0,0, 2,3));
    tbl.push_back(mk(1,0,2,1, 0,0,0,       0,0,0,       0,0,0,       0,0,0, 3,3));

    for (int i = 0; i < tbl.size(); i++) apply("table", tbl[i]);

    // 5-beat S0 packet with TVALID gaps and TREADY back-pressure
    vpat = '{1,0,1,1,0,0,1,1,1,1,1,1,1,1,1,1};
    rpat = '{1,1,0,1,1,1,0,1,0,1,1,1,1,1,1,1};
    apply("gap_pre", mk(1,0,2,1, 1,32'hF0,0, 0,0,0, 0,0,0, 0,0,0, 3,3));
    idx = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge ACLK);
      s0_if.TVALID = (cyc < 16) ? vpat[cyc] : 1'b1;
      s0_if.TDATA  = 32'hF0 + 32'(idx);
      s0_if.TLAST  = (idx == 4);
      m_if.TREADY  = (cyc < 16) ? rpat[cyc] : 1'b1;
      #1;
      chk("gap_hold", 64'({s0_if.TREADY, s1_if.TREADY, m_if.TVALID}),
                      64'({m_if.TREADY, 1'b0, s0_if.TVALID}));
      if (m_if.TVALID && m_if.TREADY) begin
        got.push_back({m_if.TLAST, m_if.TDATA});
        if (m_if.TLAST) done = 1'b1;
      end
      if (s0_if.TVALID && m_if.TREADY) idx++;
    end
    chk("gap_done", 64'(done), 64'(1));
    chk("gap_count", 64'(got.size()), 64'(5));
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk("gap_word", 64'(got[i]), 64'({(i == 4), 32'hF0 + 32'(i)}));
    apply("gap_post", mk(1,0,2,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 4,3));

    // Reset after beat 2 of a 4-beat S1 packet
    apply("rst_abort", mk(1,0,2,1, 0,0,0,      1,32'h90,0, 0,0,0,      0,0,0, 4,3));
    apply("rst_abort", mk(1,0,2,1, 0,0,0,      1,32'h90,0, 1,32'h90,0, 0,1,0, 4,3));
    apply("rst_abort", mk(1,0,2,1, 0,0,0,      1,32'h91,0, 1,32'h91,0, 0,1,0, 4,3));
    apply("rst_abort", mk(0,0,2,1, 1,32'h80,1, 1,32'h92,0, 0,0,0,      0,0,0, 4,3));
    apply("rst_abort", mk(1,0,2,1, 1,32'h80,1, 1,32'h92,0, 0,0,0,      0,0,0, 0,0));
    apply("rst_abort", mk(1,0,2,1, 1,32'h80,1, 1,32'h92,0, 1,32'h80,1, 1,0,0, 0,0));
    apply("rst_abort", mk(1,0,2,1, 0,0,0,      0,0,0,      0,0,0,      0,0,0, 1,0));

    // Single-beat S0 packets driving pkt_cnt0 through its wrap
    cur = 3'd1;
    for (int k = 0; k < 8; k++) begin
      apply("wrap", mk(1,0,2,1, 1,32'h70 + 32'(k),1, 0,0,0, 0,0,0, 0,0,0, cur,0));
      apply("wrap", mk(1,0,2,1, 1,32'h70 + 32'(k),1, 0,0,0,
                       1,32'h70 + 32'(k),1, 1,0,0, cur,0));
      cur = 3'(cur + 3'd1);
    end
    apply("wrap", mk(1,0,2,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, cur,0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
